load_store_unit: RTL and testbench
==================================

# load_store_unit

Data-memory access stage for the RV32I pipeline. It accepts one load or store from the execute stage and drives the word-wide `dbus_*` data bus. It places byte and halfword data into the correct byte lanes, sign- or zero-extends load data, and returns a single-cycle writeback response to the write stage. Only one transaction is in flight at a time.

## Interface
- No parameters. Data bus is fixed at 32 bits with 4 byte strobes.
- clk  in  1  clock; reset reset, synchronous, active-high; clock clk.
- reset  in  1  synchronous active-high reset.
- req_valid  in  1  execute stage offers a memory op.
- req_ready  out  1  LSU can accept; high only in IDLE.
- req_is_store  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I width/sign field (LB/LH/LW/LBU/LHU, SB/SH/SW).
- req_addr  in  32  effective byte address.
- req_wdata  in  32  store data, right-aligned.
- req_rd  in  5  load destination register.
- resp_valid  out  1  one-cycle completion pulse; no backpressure.
- resp_rd  out  5  destination register; 0 for stores and faults.
- resp_data  out  32  extended load data; 0 for stores and faults.
- resp_fault  out  1  misaligned access or illegal funct3.
- dbus_addr  out  32  word address, bits [1:0] always 0.
- dbus_data_wr  out  32  lane-aligned store data.
- dbus_wstrb  out  4  byte enables, meaningful when dbus_wr=1.
- dbus_rd / dbus_wr  out  1  read / write strobes, mutually exclusive.
- dbus_data_rd  in  32  read data, valid with dbus_data_ready.
- dbus_data_ready  in  1  transfer-complete pulse, sampled on clk while a strobe is high.

## Operation
- States: IDLE, ACCESS, ACCESS2 (only present with the split feature), RESP.
- IDLE:
  - Handshake is `req_valid && req_ready`.
  - The request is latched and the offset `o = req_addr[1:0]` is computed.
  - If funct3 is illegal, the request goes to RESP with fault set. Illegal means load funct3 011/110/111, or store funct3 with bit 2 set.
  - If the access is misaligned, see Configuration.
  - Otherwise the request goes to ACCESS.
- ACCESS:
  - `dbus_addr = {addr[31:2],2'b00}`.
  - Store: `dbus_data_wr = wdata << 8*o`. Strobes are `0001<<o` for SB, `0011<<o` for SH, `1111` for SW.
  - The strobe holds until dbus_data_ready is sampled high. The state then moves to RESP, or to ACCESS2 for a split access.
- Load extract:
  - `x = dbus_data_rd >> 8*o`.
  - LB sign-extends `x[7:0]`; LBU zero-extends it.
  - LH sign-extends `x[15:0]`; LHU zero-extends it.
  - LW uses x unchanged.
- RESP:
  - resp_valid is high for exactly one cycle, then the state returns to IDLE.
  - resp_* outputs are registered and are 0 whenever resp_valid=0.
- dbus_data_ready outside ACCESS/ACCESS2 is ignored.

## Timing
- Reset values:
  - State is IDLE, so req_ready=1.
  - resp_valid, resp_fault, resp_rd, resp_data are 0.
  - dbus_rd, dbus_wr, dbus_wstrb, dbus_addr, dbus_data_wr are 0.
- Accept at edge T. The strobe is high in cycle T+1.
- If ready is sampled at edge T+1, resp_valid is high in cycle T+2. Each bus wait cycle adds one cycle.
- Fault path: resp_valid is high in cycle T+1, and no strobe is asserted.
- Split access: the second strobe is high in the cycle after the first ready. Strobes stay continuous, with dbus_addr advanced by 4. Minimum response latency is T+3.
- Maximum throughput is one request per 3 cycles: req_ready returns high the cycle after resp_valid.
- Reset mid-transaction:
  - Strobes drop at the next edge.
  - The transaction is discarded and no resp_valid is produced.
  - A late dbus_data_ready is ignored.

## Configuration
- `LSU_MISALIGN_SPLIT_EN` defined: misaligned accesses are handled by splitting.
  - Within-word misaligned halfwords (o=1) are single accesses.
  - Misaligned LH/LHU/SH (o=3) and misaligned LW/SW (o≠0) split into two aligned word transfers: `addr&~3`, then `(addr&~3)+4`.
  - Store strobes are `1111<<o` for the first word and `1111>>(4-o)` for the second (halfword: `0011<<o` masked to 4 bits, then the remainder). Data is `wdata<<8o`, then `wdata>>8(4-o)`.
  - Loads merge as `{w1,w0} >> 8o` before extension.
  - resp_fault is only set for illegal funct3.
- Not defined: any halfword with addr[0]=1 or word with addr[1:0]≠0 takes the fault path. There is no bus activity, and resp_fault=1, resp_rd=0.

## Test plan
- LW addr 0x100, bus returns 0xDEADBEEF with ready in the first cycle → dbus_addr 0x100, resp_valid at T+2, resp_data 0xDEADBEEF, resp_rd = req_rd.
- LB addr 0x103, data 0x80112233 → resp_data 0xFFFFFF80. LBU same → 0x00000080. LHU addr 0x102 → 0x00008011.
- SH addr 0x206, wdata 0x1234ABCD → dbus_addr 0x204, wstrb 1100, dbus_data_wr 0xABCD0000, resp_rd 0.
- LW addr 0x301 with 3 bus wait cycles:
  - Split on: reads 0x300 (0x44332211) then 0x304 (0x88776655) → resp_data 0x55443322.
  - Split off: resp_fault at T+1, no strobe.
- Load funct3 011 → resp_fault=1 at T+1, no dbus activity. Then reset asserted during an ACCESS wait → strobe low next cycle, no resp_valid, req_ready=1.

Source files
------------

// File: rtl/load_store_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : load_store_unit                                            |
// | Description : RV32I data-memory stage. Lane placement, sign/zero         |
// |               extension and one-cycle writeback response, one access     |
// |               in flight. Define LSU_MISALIGN_SPLIT_EN to split           |
// |               misaligned accesses into two word transfers instead of     |
// |               faulting them.                                             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module load_store_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        resp_valid,
    output logic [4:0]  resp_rd,
    output logic [31:0] resp_data,
    output logic        resp_fault,
    output logic [31:0] dbus_addr,
    output logic [31:0] dbus_data_wr,
    output logic [3:0]  dbus_wstrb,
    output logic        dbus_rd,
    output logic        dbus_wr,
    input  logic [31:0] dbus_data_rd,
    input  logic        dbus_data_ready
);

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_ACCESS  = 2'd1;
`ifdef LSU_MISALIGN_SPLIT_EN
    localparam logic [1:0] c_ST_ACCESS2 = 2'd2;
`endif
    localparam logic [1:0] c_ST_RESP    = 2'd3;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;

    logic        r_is_store;
    logic [2:0]  r_funct3;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [4:0]  r_rd;

    logic        r_resp_valid;
    logic        r_resp_fault;
    logic [4:0]  r_resp_rd;
    logic [31:0] r_resp_data;

    logic        w_accept;
    logic        w_resp_set;
    logic        w_resp_fault_nxt;
    logic [4:0]  w_resp_rd_nxt;
    logic [31:0] w_resp_data_nxt;

    logic        w_req_half;
    logic        w_req_word;
    logic        w_req_illegal;
    logic        w_req_misal;
    logic        w_req_fault;
    logic        w_go_split;

    logic [1:0]  w_off;
    logic [3:0]  w_strb_base;
    logic [3:0]  w_strb_lo;
    logic [31:0] w_wdata_lo;
    logic [31:0] w_word_addr;
    logic [31:0] w_load_x;
    logic [31:0] w_load_ext;

    // Request decode, evaluated on the raw inputs while IDLE
    assign w_req_half    = (req_funct3[1:0] == 2'b01);
    assign w_req_word    = req_funct3[1];
    assign w_req_illegal = req_is_store ? req_funct3[2]
                         : ((req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11));
    assign w_req_misal   = (w_req_half && req_addr[0])
                         || (w_req_word && (req_addr[1:0] != 2'b00));

    assign w_off       = r_addr[1:0];
    assign w_word_addr = {r_addr[31:2], 2'b00};
    assign w_strb_lo   = w_strb_base << w_off;
    assign w_wdata_lo  = r_wdata << {w_off, 3'b000};

    always_comb begin
        case (r_funct3[1:0])
            2'b00:   w_strb_base = 4'b0001;
            2'b01:   w_strb_base = 4'b0011;
            default: w_strb_base = 4'b1111;
        endcase
    end

`ifdef LSU_MISALIGN_SPLIT_EN
    logic        w_req_split;
    logic        r_split;
    logic [31:0] r_word0;
    logic [3:0]  w_strb_hi;
    logic [31:0] w_wdata_hi;
    logic [63:0] w_merge;

    // Halfwords at offset 1 still fit in one word; every other misalignment crosses
    assign w_req_fault = w_req_illegal;
    assign w_req_split = !w_req_illegal && w_req_misal
                       && !(w_req_half && (req_addr[1:0] == 2'b01));
    assign w_go_split  = r_split;

    assign w_strb_hi   = w_strb_base >> (3'd4 - {1'b0, w_off});
    assign w_wdata_hi  = r_wdata >> (6'd32 - {1'b0, w_off, 3'b000});
    assign w_merge     = (r_state == c_ST_ACCESS2) ? {dbus_data_rd, r_word0}
                                                   : {32'h0, dbus_data_rd};
    assign w_load_x    = 32'(w_merge >> {w_off, 3'b000});

    always_ff @(posedge clk) begin
        if (reset) begin
            r_split <= 1'b0;
            r_word0 <= 32'h0;
        end else begin
            if (w_accept) begin
                r_split <= w_req_split;
            end
            if ((r_state == c_ST_ACCESS) && dbus_data_ready) begin
                r_word0 <= dbus_data_rd;
            end
        end
    end
`else
    assign w_req_fault = w_req_illegal || w_req_misal;
    assign w_go_split  = 1'b0;
    assign w_load_x    = dbus_data_rd >> {w_off, 3'b000};
`endif

    always_comb begin
        case (r_funct3)
            3'b000:  w_load_ext = {{24{w_load_x[7]}}, w_load_x[7:0]};
            3'b001:  w_load_ext = {{16{w_load_x[15]}}, w_load_x[15:0]};
            3'b100:  w_load_ext = {24'h0, w_load_x[7:0]};
            3'b101:  w_load_ext = {16'h0, w_load_x[15:0]};
            default: w_load_ext = w_load_x;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        req_ready        = 1'b0;
        dbus_rd          = 1'b0;
        dbus_wr          = 1'b0;
        dbus_addr        = 32'h0;
        dbus_data_wr     = 32'h0;
        dbus_wstrb       = 4'h0;
        w_accept         = 1'b0;
        w_resp_set       = 1'b0;
        w_resp_fault_nxt = 1'b0;
        w_resp_rd_nxt    = 5'h0;
        w_resp_data_nxt  = 32'h0;
        case (r_state)
            c_ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_accept = 1'b1;
                    if (w_req_fault) begin
                        w_state_nxt      = c_ST_RESP;
                        w_resp_set       = 1'b1;
                        w_resp_fault_nxt = 1'b1;
                    end else begin
                        w_state_nxt = c_ST_ACCESS;
                    end
                end
            end
            c_ST_ACCESS: begin
                dbus_rd   = !r_is_store;
                dbus_wr   = r_is_store;
                dbus_addr = w_word_addr;
                if (r_is_store) begin
                    dbus_data_wr = w_wdata_lo;
                    dbus_wstrb   = w_strb_lo;
                end
                if (dbus_data_ready) begin
                    if (w_go_split) begin
`ifdef LSU_MISALIGN_SPLIT_EN
                        w_state_nxt = c_ST_ACCESS2;
`endif
                    end else begin
                        w_state_nxt = c_ST_RESP;
                        w_resp_set  = 1'b1;
                    end
                end
            end
`ifdef LSU_MISALIGN_SPLIT_EN
            c_ST_ACCESS2: begin
                dbus_rd   = !r_is_store;
                dbus_wr   = r_is_store;
                dbus_addr = w_word_addr + 32'd4;
                if (r_is_store) begin
                    dbus_data_wr = w_wdata_hi;
                    dbus_wstrb   = w_strb_hi;
                end
                if (dbus_data_ready) begin
                    w_state_nxt = c_ST_RESP;
                    w_resp_set  = 1'b1;
                end
            end
`endif
            c_ST_RESP: begin
                w_state_nxt = c_ST_IDLE;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
        // Only successful loads return a register and data
        if (w_resp_set && !w_resp_fault_nxt && !r_is_store) begin
            w_resp_rd_nxt   = r_rd;
            w_resp_data_nxt = w_load_ext;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_is_store <= 1'b0;
            r_funct3   <= 3'h0;
            r_addr     <= 32'h0;
            r_wdata    <= 32'h0;
            r_rd       <= 5'h0;
        end else if (w_accept) begin
            r_is_store <= req_is_store;
            r_funct3   <= req_funct3;
            r_addr     <= req_addr;
            r_wdata    <= req_wdata;
            r_rd       <= req_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_resp_valid <= 1'b0;
            r_resp_fault <= 1'b0;
            r_resp_rd    <= 5'h0;
            r_resp_data  <= 32'h0;
        end else begin
            r_resp_valid <= w_resp_set;
            r_resp_fault <= w_resp_fault_nxt;
            r_resp_rd    <= w_resp_rd_nxt;
            r_resp_data  <= w_resp_data_nxt;
        end
    end

    assign resp_valid = r_resp_valid;
    assign resp_fault = r_resp_fault;
    assign resp_rd    = r_resp_rd;
    assign resp_data  = r_resp_data;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_load_store_unit                                         |
// | Description : Randomized bench for load_store_unit against a byte-level  |
// |               memory model; honours LSU_MISALIGN_SPLIT_EN.               |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_load_store_unit;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        resp_valid;
    logic [4:0]  resp_rd;
    logic [31:0] resp_data;
    logic        resp_fault;
    logic [31:0] dbus_addr;
    logic [31:0] dbus_data_wr;
    logic [3:0]  dbus_wstrb;
    logic        dbus_rd;
    logic        dbus_wr;
    logic [31:0] dbus_data_rd;
    logic        dbus_data_ready;

    load_store_unit u_dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_is_store    (req_is_store),
        .req_funct3      (req_funct3),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .req_rd          (req_rd),
        .resp_valid      (resp_valid),
        .resp_rd         (resp_rd),
        .resp_data       (resp_data),
        .resp_fault      (resp_fault),
        .dbus_addr       (dbus_addr),
        .dbus_data_wr    (dbus_data_wr),
        .dbus_wstrb      (dbus_wstrb),
        .dbus_rd         (dbus_rd),
        .dbus_wr         (dbus_wr),
        .dbus_data_rd    (dbus_data_rd),
        .dbus_data_ready (dbus_data_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // bus_mem is what the bus slave holds; ref_mem is what memory should hold
    logic [7:0] bus_mem [64];
    logic [7:0] ref_mem [64];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] bus_word(input logic [31:0] a);
        logic [5:0] i;
        i = {a[5:2], 2'b00};
        return {bus_mem[i + 6'd3], bus_mem[i + 6'd2], bus_mem[i + 6'd1], bus_mem[i]};
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        logic [5:0] i;
        i = {a[5:2], 2'b00};
        return {ref_mem[i + 6'd3], ref_mem[i + 6'd2], ref_mem[i + 6'd1], ref_mem[i]};
    endfunction

    task automatic set_word(input logic [31:0] a, input logic [31:0] v);
        for (int b = 0; b < 4; b++) begin
            bus_mem[6'(a + b)] = v[8*b +: 8];
            ref_mem[6'(a + b)] = v[8*b +: 8];
        end
    endtask

    function automatic int op_size(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic bit op_illegal(input bit st, input logic [2:0] f3);
        if (st) return f3[2];
        return (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
    endfunction

    task automatic do_op(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [4:0] rd, input int waits,
                         output logic [31:0] o_data, output logic [3:0] o_strb,
                         output logic [31:0] o_wdat);
        int          size;
        int          off;
        bit          fault;
        int          nx;
        int          exp_lat;
        logic [31:0] v;
        logic [31:0] exp_data;
        logic [4:0]  exp_rd;
        logic [31:0] base;
        int          cyc;
        int          xfer;
        int          wait_left;
        bit          in_xfer;
        bit          done;

        size     = op_size(f3);
        off      = int'(addr[1:0]);
        base     = {addr[31:2], 2'b00};
        exp_data = 32'h0;
        exp_rd   = 5'h0;
        o_data   = 32'h0;
        o_strb   = 4'h0;
        o_wdat   = 32'h0;
`ifdef LSU_MISALIGN_SPLIT_EN
        fault = op_illegal(st, f3);
        nx    = ((off + size) > 4) ? 2 : 1;
`else
        fault = op_illegal(st, f3) || ((int'(addr[1:0]) % size) != 0);
        nx    = 1;
`endif
        if (fault) begin
            nx      = 0;
            exp_lat = 1;
        end else begin
            exp_lat = 1 + nx * (waits + 1);
        end
        if (!fault && !st) begin
            v = 32'h0;
            for (int i = 0; i < size; i++) v |= 32'(ref_mem[6'(addr + i)]) << (8 * i);
            case (f3)
                3'd0:    exp_data = {{24{v[7]}}, v[7:0]};
                3'd1:    exp_data = {{16{v[15]}}, v[15:0]};
                3'd4:    exp_data = {24'h0, v[7:0]};
                3'd5:    exp_data = {16'h0, v[15:0]};
                default: exp_data = v;
            endcase
            exp_rd = rd;
        end
        if (!fault && st) begin
            for (int i = 0; i < size; i++) ref_mem[6'(addr + i)] = wdata[8*i +: 8];
        end

        dbus_data_ready = 1'b0;
        check("req_ready", req_ready, 1);
        req_valid    = 1'b1;
        req_is_store = st;
        req_funct3   = f3;
        req_addr     = addr;
        req_wdata    = wdata;
        req_rd       = rd;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_rd    = 5'($urandom);

        cyc = 1; xfer = 0; in_xfer = 0; done = 0; wait_left = 0;
        while (!done && cyc <= 40) begin
            dbus_data_ready = 1'b0;
            if (resp_valid) begin
                done = 1;
            end else if (dbus_rd || dbus_wr) begin
                check("strobe_excl", dbus_rd & dbus_wr, 0);
                if (!in_xfer) begin
                    in_xfer   = 1;
                    wait_left = waits;
                    xfer++;
                    check("dbus_addr", dbus_addr, base + 32'(4 * (xfer - 1)));
                    check("dbus_wr", dbus_wr, st);
                    if (xfer == 1) begin
                        o_strb = dbus_wstrb;
                        o_wdat = dbus_data_wr;
                    end
                end
                dbus_data_rd = bus_word(dbus_addr);
                if (wait_left == 0) begin
                    dbus_data_ready = 1'b1;
                    in_xfer = 0;
                    if (dbus_wr) begin
                        for (int b = 0; b < 4; b++)
                            if (dbus_wstrb[b]) bus_mem[6'(dbus_addr + b)] = dbus_data_wr[8*b +: 8];
                    end
                end else begin
                    wait_left--;
                end
            end
            if (!done) begin
                @(negedge clk);
                cyc++;
            end
        end
        check("resp_seen", done, 1);
        check("resp_fault", resp_fault, fault);
        check("resp_rd", resp_rd, exp_rd);
        check("resp_data", resp_data, exp_data);
        check("latency", cyc, exp_lat);
        check("xfers", xfer, nx);
        o_data = resp_data;
        @(negedge clk);
        check("resp_pulse", {resp_valid, req_ready}, 2'b01);
        check("mem_w0", bus_word(base), ref_word(base));
        check("mem_w1", bus_word(base + 32'd4), ref_word(base + 32'd4));
    endtask

    task automatic idle_gap(input int n);
        for (int k = 0; k < n; k++) begin
            dbus_data_ready = 1'($urandom_range(0, 1));
            check("idle_resp", {resp_valid, resp_fault, resp_rd, resp_data}, 0);
            check("idle_strobe", {dbus_rd, dbus_wr}, 0);
            @(negedge clk);
        end
        dbus_data_ready = 1'b0;
    endtask

    logic [31:0] d;
    logic [3:0]  s;
    logic [31:0] w;
    bit          r_st;
    logic [2:0]  r_f3;

    initial begin
        reset           = 1'b1;
        req_valid       = 1'b0;
        req_is_store    = 1'b0;
        req_funct3      = 3'h0;
        req_addr        = 32'h0;
        req_wdata       = 32'h0;
        req_rd          = 5'h0;
        dbus_data_rd    = 32'h0;
        dbus_data_ready = 1'b0;
        for (int i = 0; i < 64; i++) begin
            bus_mem[i] = 8'($urandom);
            ref_mem[i] = bus_mem[i];
        end
        repeat (3) @(negedge clk);
        check("rst_req_ready", req_ready, 1);
        check("rst_resp", {resp_valid, resp_fault, resp_rd, resp_data}, 0);
        check("rst_bus_ctl", {dbus_rd, dbus_wr, dbus_wstrb, dbus_addr}, 0);
        check("rst_bus_wdata", dbus_data_wr, 0);
        reset = 1'b0;
        @(negedge clk);

        set_word(32'h100, 32'hDEADBEEF);
        do_op(0, 3'd2, 32'h100, 32'h0, 5'd7, 0, d, s, w);
        check("lw_data", d, 32'hDEADBEEF);
        set_word(32'h100, 32'h80112233);
        do_op(0, 3'd0, 32'h103, 32'h0, 5'd3, 1, d, s, w);
        check("lb_data", d, 32'hFFFFFF80);
        do_op(0, 3'd4, 32'h103, 32'h0, 5'd4, 0, d, s, w);
        check("lbu_data", d, 32'h00000080);
        do_op(0, 3'd5, 32'h102, 32'h0, 5'd5, 2, d, s, w);
        check("lhu_data", d, 32'h00008011);
        do_op(1, 3'd1, 32'h206, 32'h1234ABCD, 5'd9, 0, d, s, w);
        check("sh_wstrb", s, 4'b1100);
        check("sh_wdata", w, 32'hABCD0000);
        set_word(32'h300, 32'h44332211);
        set_word(32'h304, 32'h88776655);
        do_op(0, 3'd2, 32'h301, 32'h0, 5'd11, 3, d, s, w);
`ifdef LSU_MISALIGN_SPLIT_EN
        check("lw_split_data", d, 32'h55443322);
`else
        check("lw_mis_data", d, 32'h0);
`endif
        do_op(0, 3'd3, 32'h100, 32'h0, 5'd12, 0, d, s, w);

        // Abort an access that is waiting on the bus
        req_valid  = 1'b1;
        req_is_store = 1'b0;
        req_funct3 = 3'd2;
        req_addr   = 32'h140;
        req_rd     = 5'd13;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("abort_strobe_on", dbus_rd, 1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("abort_strobe_off", {dbus_rd, dbus_wr}, 0);
        check("abort_ready", req_ready, 1);
        check("abort_resp", resp_valid, 0);
        reset = 1'b0;
        dbus_data_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("late_ready_resp", resp_valid, 0);
            check("late_ready_bus", {dbus_rd, dbus_wr}, 0);
        end
        dbus_data_ready = 1'b0;

        for (int n = 0; n < 150; n++) begin
            r_st = 1'($urandom_range(0, 1));
            r_f3 = 3'($urandom_range(0, 7));
            if (r_st && (r_f3 == 3'd3)) r_f3 = 3'd2;
            do_op(r_st, r_f3, $urandom, $urandom, 5'($urandom), $urandom_range(0, 3), d, s, w);
            idle_gap($urandom_range(0, 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
